// File: rtl/program_loader.sv
// Loads a checksummed big-endian byte stream into instruction memory, then releases the CPU.
// Latency: 4th byte of a word accepted in cycle t -> mem_wren in cycle t+1.
// Backpressure: in_ready high only in RECV/CHECK; bytes offered at other times are left untouched.
module program_loader #(
    parameter int TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [8:0]  word_count,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_wren,
    output logic        cpu_run,
    output logic        busy,
    output logic        err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t         state, state_nxt;
    logic [7:0]     widx;
    logic [7:0]     wlast;
    logic [1:0]     bcnt;
    logic [23:0]    asm_q;
    logic [7:0]     csum;
    logic [TW-1:0]  tcnt;

    logic xfer;
    logic start_ok;
    logic wc_ok;
    logic timeout_hit;

    assign xfer        = in_valid && in_ready;
    assign start_ok    = start && (state == IDLE || state == DONE || state == ERROR);
    assign wc_ok       = (word_count != 9'd0) && (word_count <= 9'd256);
    assign timeout_hit = !xfer && (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mem_wren  = 1'b0;
        cpu_run   = 1'b0;
        busy      = 1'b0;
        err       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_ok) state_nxt = wc_ok ? RECV : ERROR;
            end
            RECV: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (xfer && bcnt == 2'd3) state_nxt = WRITE;
                else if (timeout_hit)     state_nxt = ERROR;
            end
            WRITE: begin
                mem_wren  = 1'b1;
                busy      = 1'b1;
                state_nxt = (widx == wlast) ? CHECK : RECV;
            end
            CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (xfer)             state_nxt = (in_data == csum) ? DONE : ERROR;
                else if (timeout_hit) state_nxt = ERROR;
            end
            DONE: begin
                cpu_run = 1'b1;
                if (start_ok) state_nxt = wc_ok ? RECV : ERROR;
            end
            ERROR: begin
                err = 1'b1;
                if (start_ok) state_nxt = wc_ok ? RECV : ERROR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // mem_addr/mem_data are captured with the final byte so they are stable during WRITE and hold afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            widx     <= 8'd0;
            wlast    <= 8'd0;
            bcnt     <= 2'd0;
            asm_q    <= 24'd0;
            csum     <= 8'd0;
            tcnt     <= '0;
            mem_addr <= 8'd0;
            mem_data <= 32'd0;
        end else begin
            if (start_ok) begin
                if (wc_ok) begin
                    widx  <= 8'd0;
                    wlast <= 8'(word_count - 9'd1);
                    bcnt  <= 2'd0;
                    csum  <= 8'd0;
                    tcnt  <= '0;
                end
            end else if (state == RECV || state == CHECK) begin
                if (xfer) begin
                    tcnt <= '0;
                    if (state == RECV) begin
                        csum  <= csum ^ in_data;
                        asm_q <= {asm_q[15:0], in_data};
                        bcnt  <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            mem_addr <= widx;
                            mem_data <= {asm_q, in_data};
                        end
                    end
                end else if (!timeout_hit) begin
                    tcnt <= tcnt + 1'b1;
                end
            end else if (state == WRITE) begin
                tcnt <= '0;
                if (widx != wlast) widx <= widx + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected writes go to a scoreboard queue, a monitor checks mem_wren.
module tb_program_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [8:0]  word_count;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic        cpu_run;
    logic        busy;
    logic        err;

    program_loader #(.TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .cpu_run    (cpu_run),
        .busy       (busy),
        .err        (err)
    );

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Every write strobe must match the oldest expected write, including its cycle.
    always @(negedge clk) begin
        if (rst && mem_wren) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wr_addr", {24'd0, mem_addr}, {24'd0, e.a});
                chk("wr_data", mem_data, e.d);
                chk("wr_cycle", cyc, e.c);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [8:0] wc);
        start      = 1'b1;
        word_count = wc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL byte_accept: got no in_ready in 50 cycles expected byte %h accepted", b);
        end
    endtask

    // Called right after the 4th byte is accepted: the write is due in the following cycle.
    task automatic push_exp(input logic [7:0] a, input logic [31:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        e.c = cyc;
        q.push_back(e);
    endtask

    task automatic check_idle_outputs(input string nm);
        chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({nm, "_mem_wren"}, {31'd0, mem_wren}, 32'd0);
        chk({nm, "_cpu_run"},  {31'd0, cpu_run},  32'd0);
        chk({nm, "_busy"},     {31'd0, busy},     32'd0);
        chk({nm, "_err"},      {31'd0, err},      32'd0);
        chk({nm, "_mem_addr"}, {24'd0, mem_addr}, 32'd0);
        chk({nm, "_mem_data"}, mem_data,          32'd0);
    endtask

    logic [7:0] stream4 [16];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 expected finish");
        $fatal(1);
    end

    initial begin
        stream4 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
                    8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0, 8'hD1, 8'hD2, 8'hD7};
        rst        = 1'b1;
        start      = 1'b0;
        word_count = 9'd0;
        in_valid   = 1'b0;
        in_data    = 8'd0;
        #3 rst = 1'b0;
        #10;
        check_idle_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b1;
        idle(2);

        // Single word, good checksum.
        do_start(9'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
        send_byte(8'h8C);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h04);
        push_exp(8'h00, 32'h8C010004);
        send_byte(8'h89);
        chk("t1_cpu_run", {31'd0, cpu_run}, 32'd1);
        chk("t1_busy_done", {31'd0, busy}, 32'd0);
        chk("t1_err", {31'd0, err}, 32'd0);
        idle(2);
        chk("t1_hold_data", mem_data, 32'h8C010004);

        // Zero word count from DONE.
        do_start(9'd0);
        chk("zero_wc_err", {31'd0, err}, 32'd1);
        chk("zero_wc_cpu_run", {31'd0, cpu_run}, 32'd0);
        chk("zero_wc_busy", {31'd0, busy}, 32'd0);

        // Two words with gapped stream and an ignored start mid-load.
        do_start(9'd2);
        chk("t2_err_cleared", {31'd0, err}, 32'd0);
        chk("t2_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            idle(3);
            send_byte(8'(i));
            if (i == 3) push_exp(8'h00, 32'h00010203);
            if (i == 7) push_exp(8'h01, 32'h04050607);
            if (i == 1) begin
                do_start(9'd1);
                chk("t2_start_ignored", {31'd0, busy}, 32'd1);
            end
        end
        send_byte(8'h00);
        chk("t2_cpu_run", {31'd0, cpu_run}, 32'd1);
        chk("t2_err", {31'd0, err}, 32'd0);

        // Oversized word count.
        do_start(9'd300);
        chk("big_wc_err", {31'd0, err}, 32'd1);

        // Bad checksum.
        do_start(9'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        push_exp(8'h00, 32'h11223344);
        send_byte(8'hFF);
        chk("t3_err", {31'd0, err}, 32'd1);
        chk("t3_cpu_run", {31'd0, cpu_run}, 32'd0);
        chk("t3_busy", {31'd0, busy}, 32'd0);

        // Timeout mid-word.
        do_start(9'd1);
        chk("t4_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h8C);
        send_byte(8'h01);
        idle(7);
        chk("t4_err_before", {31'd0, err}, 32'd0);
        idle(1);
        chk("t4_err_timeout", {31'd0, err}, 32'd1);
        chk("t4_in_ready", {31'd0, in_ready}, 32'd0);

        // Reset mid-session after 2nd byte of word index 2.
        do_start(9'd4);
        for (int i = 0; i < 10; i++) begin
            send_byte(stream4[i]);
            if (i == 3) push_exp(8'h00, 32'hA0A1A2A3);
            if (i == 7) push_exp(8'h01, 32'hB0B1B2B3);
        end
        #2 rst = 1'b0;
        #1;
        check_idle_outputs("midrst");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        idle(3);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd0);

        // Fresh full load after reset.
        do_start(9'd4);
        for (int i = 0; i < 16; i++) begin
            send_byte(stream4[i]);
            if (i == 3)  push_exp(8'h00, 32'hA0A1A2A3);
            if (i == 7)  push_exp(8'h01, 32'hB0B1B2B3);
            if (i == 11) push_exp(8'h02, 32'hC0C1C2C3);
            if (i == 15) push_exp(8'h03, 32'hD0D1D2D7);
        end
        send_byte(8'h04);
        chk("t6_cpu_run", {31'd0, cpu_run}, 32'd1);
        chk("t6_err", {31'd0, err}, 32'd0);

        idle(4);
        chk("pending_writes", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter TIMEOUT, default 1000: idle-cycle limit between accepted bytes in RECV/CHECK before ERROR.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle request to begin a load session.
REQ-005 word_count  in  9  number of 32-bit words to load (1..256); sampled only when start is accepted.
REQ-006 in_valid  in  1  byte-stream source has a byte on in_data.
REQ-007 in_data  in  8  stream byte.
REQ-008 in_ready  out  1  loader accepts in_data this cycle; transfer occurs when in_valid & in_ready.
REQ-009 mem_addr  out  8  instruction-memory word address.
REQ-010 mem_data  out  32  instruction word to write.
REQ-011 mem_wren  out  1  one-cycle write strobe to instruction memory.
REQ-012 cpu_run  out  1  processor enable/reset-release; high only after a successful load.
REQ-013 busy  out  1  high in RECV, WRITE, CHECK.
REQ-014 err  out  1  high in ERROR.

Function
REQ-015 FSM states: IDLE, RECV, WRITE, CHECK, DONE, ERROR.
REQ-016 start is accepted in IDLE, DONE or ERROR; ignored in RECV, WRITE, CHECK.
REQ-017 On accepted start with word_count in 1..256: next state RECV; word index, byte counter, XOR checksum and timeout counter cleared; cpu_run low from the next cycle.
REQ-018 On accepted start with word_count = 0 or > 256: next state ERROR, no memory writes.
REQ-019 RECV: in_ready = 1; each accepted byte shifts into a 32-bit assembly register, big-endian (first byte -> bits 31:24), and XORs into the 8-bit running checksum.
REQ-020 The 4th accepted byte of a word (byte counter 3) moves the FSM to WRITE; the byte counter wraps to 0.
REQ-021 WRITE: lasts exactly one cycle; mem_wren = 1, mem_addr = word index, mem_data = assembled word; in_ready = 0.
REQ-022 Latency: 4th byte accepted in cycle t -> mem_wren high in cycle t+1 only.
REQ-023 After WRITE: if word index = word_count-1 -> CHECK; else word index increments by 1 and the FSM returns to RECV.
REQ-024 CHECK: in_ready = 1; one accepted byte is compared with the running checksum; equal -> DONE, unequal -> ERROR.
REQ-025 Timeout counter clears on every accepted byte and on entry to RECV/CHECK; it increments in RECV/CHECK on cycles without a transfer; reaching TIMEOUT forces ERROR, including mid-word.
REQ-026 DONE: cpu_run = 1, in_ready = 0, busy = 0, err = 0; held until an accepted start.
REQ-027 ERROR: cpu_run = 0, err = 1, in_ready = 0; held until an accepted start.
REQ-028 mem_wren is 0 in every state except WRITE; mem_addr/mem_data hold their last values outside WRITE.
REQ-029 Word index never exceeds 255 because word_count <= 256.
REQ-030 Bytes presented while in_ready = 0 are not consumed and do not affect checksum or counters.

Reset
REQ-031 rst low asynchronously forces IDLE; in_ready, mem_wren, cpu_run, busy and err = 0; mem_addr = 0; mem_data = 0; all counters and checksum = 0.
REQ-032 rst asserted mid-session aborts the load immediately, with no further mem_wren; after release the FSM stays in IDLE until start.

Verification
REQ-033 word_count=1, bytes 8C,01,00,04 then checksum 89 -> one write, mem_addr=00, mem_data=8C010004; DONE, cpu_run=1.
REQ-034 word_count=2, bytes 00..07 with in_valid gapped by 3 idle cycles, then checksum 00 -> writes at addr 00 (00010203) and 01 (04050607); each mem_wren occurs one cycle after its 4th byte; DONE.
REQ-035 word_count=1, bytes 11,22,33,44, checksum FF (correct 44) -> one write, then ERROR, err=1, cpu_run=0.
REQ-036 TIMEOUT=8, word_count=1, two bytes then in_valid low for 8 cycles -> ERROR, no mem_wren.
REQ-037 rst pulsed low after the 2nd byte of word 3 of 4 -> outputs zero immediately, IDLE after release; a fresh start with a valid stream reaches DONE.
REQ-038 start with word_count=0 -> ERROR next cycle; start pulsed during RECV -> ignored, and the load completes normally.
